// File: rtl/shift_left_seq_32_if.sv
// Request/response bundle for the sequential shift-left unit.
// master drives the request; slave (the shifter) drives status and result.
interface shift_left_seq_32_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry_out;

  modport master (
    output start, a, shamt,
    input  busy, done, out, carry_out
  );

  modport slave (
    input  start, a, shamt,
    output busy, done, out, carry_out
  );
endinterface

// File: rtl/shift_left_seq_32.sv
// Multi-cycle logical shift-left, one bit per clock, result with a one-cycle done pulse.
// Optional macro SHL_CARRY_OUT_EN: carry_out reports the last bit shifted out of the MSB.
module shift_left_seq_32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_left_seq_32_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] work_shl_s;
`ifdef SHL_CARRY_OUT_EN
  logic             carry_out_q, carry_out_d;
`endif

  assign work_shl_s = {work_q[WIDTH-2:0], 1'b0};

  // Next-state and output-register computation; outputs are loaded on the edge entering FIN
  // so that done and the final result appear together in the FIN cycle.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
`ifdef SHL_CARRY_OUT_EN
    carry_out_d = carry_out_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d = bus.a;
          cnt_d  = bus.shamt;
          if (bus.shamt == {SHW{1'b0}}) begin
            state_d = S_FIN;
            out_d   = bus.a;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`ifdef SHL_CARRY_OUT_EN
            carry_out_d = 1'b0;
`endif
          end else begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SHIFT: begin
        work_d = work_shl_s;
        cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          state_d = S_FIN;
          out_d   = work_shl_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef SHL_CARRY_OUT_EN
          carry_out_d = work_q[WIDTH-1];
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= {SHW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= {WIDTH{1'b0}};
`ifdef SHL_CARRY_OUT_EN
      carry_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
`ifdef SHL_CARRY_OUT_EN
      carry_out_q <= carry_out_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
`ifdef SHL_CARRY_OUT_EN
  assign bus.carry_out = carry_out_q;
`else
  assign bus.carry_out = 1'b0;
`endif

endmodule
